ham_calc: RTL and testbench
===========================

Name: ham_calc

Overview:
- Computes the Ising Hamiltonian of one spin configuration by streaming the coupling matrix row by row from weight memory.
- Sits directly upstream of the best-energy comparator.
- Drives that stage's hamiltonian_energy, cal_done and save_spin_array inputs, one pulse per evaluated configuration.

Parameters:
NUM_ROW, 46, number of spins and matrix rows/columns.
W_WIDTH, 4, signed coupling weight width.
ENERGY_WIDTH, 14, energy output is ENERGY_WIDTH+1 bits signed.

Ports:
clk  input  1  clock, rising edge.
resetb  input  1  asynchronous active-low reset.
start  input  1  request evaluation of spin_array. Sampled only in IDLE or DONE.
spin_array  input  NUM_ROW  spin bits: 1 = +1, 0 = -1.
w_rd_en  output  1  weight row read strobe.
w_addr  output  clog2(NUM_ROW)  row index i.
w_rdata  input  NUM_ROW*W_WIDTH  row i. w_rdata[j*W_WIDTH +: W_WIDTH] = J_ij, signed. Valid the cycle after w_rd_en.
busy  output  1  evaluation in progress.
hamiltonian_energy  output  ENERGY_WIDTH+1  signed energy of last evaluation.
cal_done  output  1  one-cycle pulse when hamiltonian_energy updates.
save_spin_array  output  NUM_ROW  spins belonging to hamiltonian_energy.

Behaviour:
- Reset (resetb low, asynchronous):
  - state=IDLE
  - all outputs 0
  - internal accumulator and latched spins 0
- Reset mid-evaluation aborts with no cal_done. Outputs return to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE:
  - On start=1, latch spin_array into spin_r, clear accumulator, rd_cnt=0, go to RUN.
  - DONE with start=0 goes to IDLE.
  - start in RUN/DRAIN is ignored.
- RUN:
  - w_rd_en=1, w_addr=rd_cnt, rd_cnt increments each cycle.
  - After issuing row NUM_ROW-1, go to DRAIN.
- Accumulation:
  - Row i data arrives the cycle after its read. Rows are accumulated in the cycles RUN+1 through DRAIN.
  - Row term for row i = sum over j of t_ij:
    - j>i: t_ij = +J_ij if spin_r[i]==spin_r[j], else -J_ij.
    - j==i (local field): t_ii = +J_ii if spin_r[i]=1, else -J_ii.
    - j<i: t_ij = 0. The lower triangle is ignored regardless of content.
  - Row sum is combinational, width W_WIDTH+clog2(NUM_ROW)+2, signed.
  - Accumulator width ENERGY_WIDTH+8, signed, no wrap for legal parameters.
- DRAIN: one cycle, accumulates the last row, then registers outputs and goes to DONE.
- Output update, at the end of DRAIN:
  - hamiltonian_energy = accumulator saturated to [-2^ENERGY_WIDTH, 2^ENERGY_WIDTH-1]. Defaults: [-16384, 16383]. 16383 = 'h3FFF, the comparator's idle minimum.
  - save_spin_array = spin_r.
  - cal_done=1 for exactly the DONE cycle.
- Outputs hold until the next DONE. save_spin_array and hamiltonian_energy are always a matched pair.
- Latency:
  - start sampled at edge E0.
  - w_rd_en high for cycles 1..NUM_ROW.
  - cal_done high in cycle NUM_ROW+2.
- busy=1 in RUN and DRAIN only.
- Back-to-back: start during DONE begins the next evaluation immediately. Throughput is one result per NUM_ROW+2 cycles.
- w_addr holds its last value when w_rd_en=0. w_rdata is ignored except the cycle after a read.

Test Plan:
- Reset:
  - Stimulus: assert resetb low with X on inputs.
  - Required: all outputs 0, busy=0, no w_rd_en; after release, with no start, outputs stay 0.
- Upper-triangle coupling (NUM_ROW=4, W_WIDTH=4, only J_01=3):
  - Stimulus: spins 4'b0011.
  - Required: hamiltonian_energy=+3, cal_done exactly in cycle 6 after start edge, save_spin_array=4'b0011.
  - Stimulus: spins 4'b0001.
  - Required: -3.
- Local field and lower triangle:
  - Stimulus: J_22=-5 and J_10=7, spins 4'b0000.
  - Required: +5. J_10 contributes nothing.
- Saturation (NUM_ROW=4, ENERGY_WIDTH=6):
  - Stimulus: all J=+7, all spins 1.
  - Required: raw 70, hamiltonian_energy=63.
  - Stimulus: all J=-8, all spins 1.
  - Required: raw -80, hamiltonian_energy=-64.
- Handshake:
  - Stimulus: start pulsed again in cycle 2.
  - Required: ignored, a single cal_done.
  - Stimulus: start held high.
  - Required: back-to-back cal_done every 6 cycles, with matching spin/energy pairs.
  - Stimulus: resetb low in cycle 3.
  - Required: no cal_done, outputs 0, FSM IDLE.
- Default parameters (NUM_ROW=46, random J and spins, 200 iterations):
  - Stimulus: random evaluations checked against a reference model.
  - Required: energy matches the reference model; w_addr sequence is 0..45.

Source files
------------

// File: rtl/ham_calc_if.sv
// Port bundle for ham_calc: spin request, weight-row read channel and result channel.
// The master modport is the calculator, the slave modport is its environment.
interface ham_calc_if #(
    parameter int NUM_ROW      = 46,
    parameter int W_WIDTH      = 4,
    parameter int ENERGY_WIDTH = 14
);
    localparam int AW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

    // Handshakes: start is a request taken only when the calculator is not busy (IDLE/DONE),
    // otherwise dropped; w_rd_en is a read strobe with w_rdata returned exactly one cycle
    // later and no backpressure; cal_done is a one-cycle valid for the result pair.
    logic                          start;
    logic [NUM_ROW-1:0]            spin_array;
    logic                          w_rd_en;
    logic [AW-1:0]                 w_addr;
    logic [NUM_ROW*W_WIDTH-1:0]    w_rdata;
    logic                          busy;
    logic signed [ENERGY_WIDTH:0]  hamiltonian_energy;
    logic                          cal_done;
    logic [NUM_ROW-1:0]            save_spin_array;
    logic [1:0]                    dbg_state;

    modport master (
        input  start, spin_array, w_rdata,
        output w_rd_en, w_addr, busy, hamiltonian_energy, cal_done, save_spin_array, dbg_state
    );

    modport slave (
        output start, spin_array, w_rdata,
        input  w_rd_en, w_addr, busy, hamiltonian_energy, cal_done, save_spin_array, dbg_state
    );
endinterface

// File: rtl/ham_calc.sv
// Ising Hamiltonian of one spin configuration: streams coupling rows, sums the upper
// triangle plus local field, and emits a saturated energy with the matching spins.
module ham_calc #(
    parameter int NUM_ROW      = 46,
    parameter int W_WIDTH      = 4,
    parameter int ENERGY_WIDTH = 14
) (
    input  logic       clk,
    input  logic       resetb,
    ham_calc_if.master bus
);
    localparam int AW    = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam int RS_W  = W_WIDTH + AW + 2;
    localparam int ACC_W = ENERGY_WIDTH + 8;
    localparam logic signed [ACC_W-1:0] E_MAX = {{(ACC_W-ENERGY_WIDTH){1'b0}}, {ENERGY_WIDTH{1'b1}}};
    localparam logic signed [ACC_W-1:0] E_MIN = ~E_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                       state_q;
    logic [AW-1:0]                addr_q;
    logic                         rd_en_q;
    logic                         row_vld_q;
    logic [AW-1:0]                row_idx_q;
    logic [NUM_ROW-1:0]           spin_q;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_d;
    logic signed [ENERGY_WIDTH:0] energy_q;
    logic signed [ENERGY_WIDTH:0] energy_d;
    logic [NUM_ROW-1:0]           save_q;
    logic                         done_q;
    logic                         busy_q;

    logic signed [RS_W-1:0]       row_sum;
    logic signed [RS_W-1:0]       j_ext;
    logic [W_WIDTH-1:0]           j_val;
    logic                         spin_i;
    logic signed [ACC_W-1:0]      row_ext;

    // Row term: upper triangle by spin agreement, diagonal by the row's own spin,
    // lower triangle discarded.
    always_comb begin
        row_sum = '0;
        j_val   = '0;
        j_ext   = '0;
        spin_i  = spin_q[row_idx_q];
        for (int j = 0; j < NUM_ROW; j++) begin
            j_val = bus.w_rdata[j*W_WIDTH +: W_WIDTH];
            j_ext = {{(RS_W-W_WIDTH){j_val[W_WIDTH-1]}}, j_val};
            if (j > int'(row_idx_q)) begin
                row_sum = row_sum + ((spin_i == spin_q[j]) ? j_ext : -j_ext);
            end else if (j == int'(row_idx_q)) begin
                row_sum = row_sum + (spin_i ? j_ext : -j_ext);
            end
        end
    end

    always_comb begin
        row_ext = {{(ACC_W-RS_W){row_sum[RS_W-1]}}, row_sum};
        acc_d   = row_vld_q ? (acc_q + row_ext) : acc_q;
        if (acc_d > E_MAX) begin
            energy_d = E_MAX[ENERGY_WIDTH:0];
        end else if (acc_d < E_MIN) begin
            energy_d = E_MIN[ENERGY_WIDTH:0];
        end else begin
            energy_d = acc_d[ENERGY_WIDTH:0];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            row_vld_q <= 1'b0;
            row_idx_q <= '0;
            spin_q    <= '0;
            acc_q     <= '0;
            energy_q  <= '0;
            save_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            row_vld_q <= rd_en_q;
            row_idx_q <= addr_q;
            acc_q     <= acc_d;
            done_q    <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        spin_q  <= bus.spin_array;
                        acc_q   <= '0;
                        addr_q  <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (addr_q == AW'(NUM_ROW-1)) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    energy_q <= energy_d;
                    save_q   <= spin_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.w_rd_en            = rd_en_q;
    assign bus.w_addr             = addr_q;
    assign bus.busy               = busy_q;
    assign bus.hamiltonian_energy = energy_q;
    assign bus.cal_done           = done_q;
    assign bus.save_spin_array    = save_q;
    assign bus.dbg_state          = state_q;
endmodule

// File: tb/tb_ham_calc.sv
// Bench for ham_calc: a small instance (4 spins, 6-bit energy) for directed cases and a
// default instance for randomized evaluations, both checked cycle by cycle against a model.
module tb_ham_calc;
    localparam int NS = 4;
    localparam int ES = 6;
    localparam int ND = 46;
    localparam int ED = 14;
    localparam int WW = 4;

    logic clk  = 1'b0;
    logic rb_s = 1'b0;
    logic rb_d = 1'b0;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ham_calc_if #(.NUM_ROW(NS), .W_WIDTH(WW), .ENERGY_WIDTH(ES)) bs();
    ham_calc_if #(.NUM_ROW(ND), .W_WIDTH(WW), .ENERGY_WIDTH(ED)) bd();

    ham_calc #(.NUM_ROW(NS), .W_WIDTH(WW), .ENERGY_WIDTH(ES)) u_small (.clk(clk), .resetb(rb_s), .bus(bs));
    ham_calc #(.NUM_ROW(ND), .W_WIDTH(WW), .ENERGY_WIDTH(ED)) u_dflt  (.clk(clk), .resetb(rb_d), .bus(bd));

    // Coupling matrices and model state
    int js[NS][NS];
    int jd[ND][ND];
    int last_s = -100;
    int last_d = -100;

    logic signed [ES:0] exp_q_s[$];
    logic [NS-1:0]      exp_spin_s[$];
    int                 exp_cyc_s[$];
    logic signed [ED:0] exp_q_d[$];
    logic [ND-1:0]      exp_spin_d[$];
    int                 exp_cyc_d[$];

    logic signed [ES:0] held_es = '0;
    logic [NS-1:0]      held_ss = '0;
    logic signed [ED:0] held_ed = '0;
    logic [ND-1:0]      held_sd = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int e, input int ew);
        int lim = 1 << ew;
        if (e > lim - 1) return lim - 1;
        if (e < -lim) return -lim;
        return e;
    endfunction

    // Energy = sum_i s_i*J_ii + sum_{i<j} s_i*s_j*J_ij with s = +/-1
    function automatic int energy_s(input logic [NS-1:0] sp);
        int e = 0;
        for (int i = 0; i < NS; i++)
            for (int j = i; j < NS; j++)
                e += (i == j) ? ((sp[i] ? 1 : -1) * js[i][i])
                              : ((sp[i] ? 1 : -1) * (sp[j] ? 1 : -1) * js[i][j]);
        return e;
    endfunction

    function automatic int energy_d(input logic [ND-1:0] sp);
        int e = 0;
        for (int i = 0; i < ND; i++)
            for (int j = i; j < ND; j++)
                e += (i == j) ? ((sp[i] ? 1 : -1) * jd[i][i])
                              : ((sp[i] ? 1 : -1) * (sp[j] ? 1 : -1) * jd[i][j]);
        return e;
    endfunction

    function automatic logic [NS*WW-1:0] pack_s(input int r);
        logic [NS*WW-1:0] v = '0;
        for (int j = 0; j < NS; j++) v[j*WW +: WW] = 4'(js[r][j]);
        return v;
    endfunction

    function automatic logic [ND*WW-1:0] pack_d(input int r);
        logic [ND*WW-1:0] v = '0;
        for (int j = 0; j < ND; j++) v[j*WW +: WW] = 4'(jd[r][j]);
        return v;
    endfunction

    function automatic logic [ND*WW-1:0] rand_d();
        logic [191:0] v;
        for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
        return v[ND*WW-1:0];
    endfunction

    function automatic logic [ND-1:0] rand_spins_d();
        logic [63:0] v = {$urandom, $urandom};
        return v[ND-1:0];
    endfunction

    // Weight memories: row returned one cycle after the read, noise otherwise
    always @(posedge clk) begin
        if (bs.w_rd_en) bs.w_rdata <= (int'(bs.w_addr) < NS) ? pack_s(int'(bs.w_addr)) : '0;
        else            bs.w_rdata <= 16'($urandom);
        if (bd.w_rd_en) bd.w_rdata <= (int'(bd.w_addr) < ND) ? pack_d(int'(bd.w_addr)) : '0;
        else            bd.w_rdata <= rand_d();
    end

    // Scoreboard for the small instance
    always @(negedge clk) begin
        int  k;
        logic exp_done;
        k = cyc;
        exp_done = 1'b0;
        if (!rb_s) begin
            exp_q_s.delete(); exp_spin_s.delete(); exp_cyc_s.delete();
            held_es = '0; held_ss = '0;
        end
        if (exp_cyc_s.size() > 0 && exp_cyc_s[0] == k) begin
            exp_done = 1'b1;
            held_es  = exp_q_s.pop_front();
            held_ss  = exp_spin_s.pop_front();
            void'(exp_cyc_s.pop_front());
        end
        chk("s_cal_done", bs.cal_done, exp_done);
        chk("s_busy", bs.busy, (k >= last_s + 1) && (k <= last_s + NS + 1));
        chk("s_rd_en", bs.w_rd_en, (k >= last_s + 1) && (k <= last_s + NS));
        if ((k >= last_s + 1) && (k <= last_s + NS)) chk("s_w_addr", bs.w_addr, k - last_s - 1);
        chk("s_energy", bs.hamiltonian_energy, held_es);
        chk("s_spins", bs.save_spin_array, held_ss);
    end

    // Scoreboard for the default instance
    always @(negedge clk) begin
        int  k;
        logic exp_done;
        k = cyc;
        exp_done = 1'b0;
        if (!rb_d) begin
            exp_q_d.delete(); exp_spin_d.delete(); exp_cyc_d.delete();
            held_ed = '0; held_sd = '0;
        end
        if (exp_cyc_d.size() > 0 && exp_cyc_d[0] == k) begin
            exp_done = 1'b1;
            held_ed  = exp_q_d.pop_front();
            held_sd  = exp_spin_d.pop_front();
            void'(exp_cyc_d.pop_front());
        end
        chk("d_cal_done", bd.cal_done, exp_done);
        chk("d_busy", bd.busy, (k >= last_d + 1) && (k <= last_d + ND + 1));
        chk("d_rd_en", bd.w_rd_en, (k >= last_d + 1) && (k <= last_d + ND));
        if ((k >= last_d + 1) && (k <= last_d + ND)) chk("d_w_addr", bd.w_addr, k - last_d - 1);
        chk("d_energy", bd.hamiltonian_energy, held_ed);
        chk("d_spins", bd.save_spin_array, held_sd);
    end

    task automatic rand_js();
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++) js[i][j] = int'($urandom_range(0, 15)) - 8;
    endtask

    task automatic set_js(input int v);
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++) js[i][j] = v;
    endtask

    // One cycle of small-instance stimulus; the model accepts start only outside RUN/DRAIN
    task automatic drive_s(input logic st, input logic [NS-1:0] sp, input bit rnd_j);
        @(posedge clk); #1;
        bs.start = st;
        bs.spin_array = sp;
        if (st && (cyc > last_s + NS + 1)) begin
            if (rnd_j) rand_js();
            exp_q_s.push_back((ES+1)'(sat(energy_s(sp), ES)));
            exp_spin_s.push_back(sp);
            exp_cyc_s.push_back(cyc + NS + 2);
            last_s = cyc;
        end
    endtask

    task automatic run_s(input logic [NS-1:0] sp, input int raw, input int lit);
        int k;
        bit seen = 0;
        chk("model_pin", energy_s(sp), raw);
        drive_s(1'b1, sp, 1'b0);
        k = last_s;
        drive_s(1'b0, '0, 1'b0);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bs.cal_done;
        end
        chk("done_latency", cyc - k, 6);
        chk("lit_energy", bs.hamiltonian_energy, lit);
        chk("lit_spins", bs.save_spin_array, sp);
    endtask

    initial begin
        int pushes;
        logic [ND-1:0] sp;

        set_js(0);
        for (int i = 0; i < ND; i++)
            for (int j = 0; j < ND; j++) jd[i][j] = 0;
        bs.start = 1'bx;
        bs.spin_array = 'x;
        bd.start = 1'b0;
        bd.spin_array = '0;

        // Reset with unknown inputs
        repeat (3) @(negedge clk);
        chk("rst_state", bs.dbg_state, 0);
        chk("rst_rd_en", bs.w_rd_en, 0);
        chk("rst_busy", bs.busy, 0);
        chk("rst_energy", bs.hamiltonian_energy, 0);
        chk("rst_spins", bs.save_spin_array, 0);
        @(posedge clk); #1;
        bs.start = 1'b0;
        bs.spin_array = '0;
        rb_s = 1'b1;
        rb_d = 1'b1;
        repeat (5) @(posedge clk);

        // Upper triangle, local field, lower triangle ignored
        js[0][1] = 3;
        run_s(4'b0011, 3, 3);
        run_s(4'b0001, -3, -3);
        set_js(0);
        js[2][2] = -5;
        js[1][0] = 7;
        run_s(4'b0000, 5, 5);

        // Saturation at the 7-bit energy limits
        set_js(7);
        run_s(4'b1111, 70, 63);
        set_js(-8);
        run_s(4'b1111, -80, -64);

        // Second start in cycle 2 must be dropped
        rand_js();
        drive_s(1'b1, 4'b1010, 1'b0);
        drive_s(1'b0, 4'b0000, 1'b0);
        drive_s(1'b1, 4'b0101, 1'b0);
        drive_s(1'b0, 4'b0000, 1'b0);
        repeat (8) drive_s(1'b0, 4'b0000, 1'b0);

        // Start held high: back-to-back evaluations every NS+2 cycles
        for (int n = 0; n < 26; n++) drive_s(1'b1, 4'($urandom), 1'b1);
        repeat (8) drive_s(1'b0, 4'b0000, 1'b0);

        // Reset in cycle 3 of an evaluation
        drive_s(1'b1, 4'b1100, 1'b1);
        drive_s(1'b0, 4'b0000, 1'b0);
        drive_s(1'b0, 4'b0000, 1'b0);
        @(posedge clk); #1;
        rb_s = 1'b0;
        last_s = -100;
        @(negedge clk);
        chk("abort_state", bs.dbg_state, 0);
        chk("abort_busy", bs.busy, 0);
        chk("abort_energy", bs.hamiltonian_energy, 0);
        chk("abort_spins", bs.save_spin_array, 0);
        @(posedge clk); #1;
        rb_s = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_idle", bs.dbg_state, 0);

        // Randomized evaluations on the default-size instance
        pushes = 0;
        for (int n = 0; n < 30000 && pushes < 200; n++) begin
            @(posedge clk); #1;
            if (cyc > last_d + ND + 1) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int i = 0; i < ND; i++)
                        for (int j = 0; j < ND; j++) jd[i][j] = int'($urandom_range(0, 15)) - 8;
                    sp = rand_spins_d();
                    bd.start = 1'b1;
                    bd.spin_array = sp;
                    exp_q_d.push_back((ED+1)'(sat(energy_d(sp), ED)));
                    exp_spin_d.push_back(sp);
                    exp_cyc_d.push_back(cyc + ND + 2);
                    last_d = cyc;
                    pushes++;
                end else begin
                    bd.start = 1'b0;
                end
            end else begin
                bd.start = 1'($urandom_range(0, 1));
                bd.spin_array = rand_spins_d();
            end
        end
        @(posedge clk); #1;
        bd.start = 1'b0;
        chk("d_evals", pushes, 200);
        repeat (ND + 4) @(posedge clk);
        @(negedge clk);
        chk("d_pending", exp_q_d.size(), 0);
        chk("s_pending", exp_q_s.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
